// File: rtl/lj_pair_dispatcher.sv
// Streams every unique particle pair (i<j) from a position memory to the LJ force tile.
// One ref read per row, then one neighbor read per pair, buffered in a 2-entry output FIFO.
module lj_pair_dispatcher #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ID_WIDTH:0]       particle_count,
   output logic                    busy,
   output logic                    done,
   output logic                    rd_en,
   output logic [ID_WIDTH-1:0]     rd_addr,
   input  logic [4*DATA_WIDTH-1:0] rd_data,
   output logic                    pair_valid,
   input  logic                    pair_ready,
   output logic [4*DATA_WIDTH-1:0] ref_pos,
   output logic [4*DATA_WIDTH-1:0] neighbor,
   output logic [ID_WIDTH-1:0]     ref_id,
   output logic [ID_WIDTH-1:0]     neighbor_id,
   output logic                    last_pair,
   output logic [2:0]              fsm_state
);

   localparam int PW = 4 * DATA_WIDTH;
   localparam logic [ID_WIDTH:0] ONE = (ID_WIDTH + 1)'(1);
   localparam logic [ID_WIDTH:0] TWO = (ID_WIDTH + 1)'(2);

   typedef enum logic [2:0] {IDLE, LOAD_REF, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [PW-1:0]       r;
      logic [PW-1:0]       nb;
      logic [ID_WIDTH-1:0] ri;
      logic [ID_WIDTH-1:0] ni;
      logic                last;
   } entry_t;

   state_t              state, state_nx;
   logic [ID_WIDTH:0]   n_reg, ci, cj;
   logic                ref_load;
   logic [PW-1:0]       ref_reg;
   logic                fl_valid, fl_last;
   logic [ID_WIDTH-1:0] fl_i, fl_j;
   entry_t              mem [2];
   entry_t              head;
   logic                wr_ptr, rd_ptr;
   logic [1:0]          count;
   logic [2:0]          occ;
   logic                push, pop, credit, issue, row_end, final_pair;

   // Handshake: a pair transfers on a cycle where pair_valid && pair_ready; the head
   // entry holds until then.
   assign push       = fl_valid;
   assign pop        = (count != 2'd0) && pair_ready;
   // Occupancy net of this cycle's pop, so steady streaming sustains one read per cycle.
   assign occ        = {1'b0, count} + {2'b00, fl_valid} - {2'b00, pop};
   assign credit     = occ < 3'd2;
   assign row_end    = (cj == n_reg - ONE);
   assign final_pair = row_end && (ci == n_reg - TWO);

   always_comb begin
      state_nx = state;
      rd_en    = 1'b0;
      issue    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = (particle_count < TWO) ? DRAIN : LOAD_REF;
         end
         LOAD_REF: begin
            busy     = 1'b1;
            rd_en    = 1'b1;
            state_nx = ISSUE;
         end
         ISSUE: begin
            busy = 1'b1;
            if (credit) begin
               rd_en = 1'b1;
               issue = 1'b1;
               if (row_end) state_nx = final_pair ? DRAIN : LOAD_REF;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (!fl_valid && (count == 2'd0 || (count == 2'd1 && pop))) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         n_reg    <= '0;
         ci       <= '0;
         cj       <= '0;
         ref_load <= 1'b0;
         ref_reg  <= '0;
         fl_valid <= 1'b0;
         fl_last  <= 1'b0;
         fl_i     <= '0;
         fl_j     <= '0;
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
      end else begin
         state    <= state_nx;
         ref_load <= (state == LOAD_REF);
         if (ref_load) ref_reg <= rd_data;
         if (state == IDLE && start) begin
            n_reg <= particle_count;
            ci    <= '0;
         end
         if (state == LOAD_REF) cj <= ci + ONE;
         if (issue) begin
            cj <= cj + ONE;
            if (row_end && !final_pair) ci <= ci + ONE;
         end
         // Tag travels with the read so the returning word lands with its ids.
         fl_valid <= issue;
         fl_i     <= ci[ID_WIDTH-1:0];
         fl_j     <= cj[ID_WIDTH-1:0];
         fl_last  <= issue && final_pair;
         if (push) begin
            mem[wr_ptr] <= '{r: ref_reg, nb: rd_data, ri: fl_i, ni: fl_j, last: fl_last};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign rd_addr     = !rd_en ? '0 : (state == LOAD_REF) ? ci[ID_WIDTH-1:0] : cj[ID_WIDTH-1:0];
   assign head        = mem[rd_ptr];
   assign pair_valid  = (count != 2'd0);
   assign ref_pos     = head.r;
   assign neighbor    = head.nb;
   assign ref_id      = head.ri;
   assign neighbor_id = head.ni;
   assign last_pair   = pair_valid && head.last;
   assign fsm_state   = state;

endmodule

// File: tb/tb_lj_pair_dispatcher.sv
// Bench for lj_pair_dispatcher: random positions and stalls against a pair-list model
// built from nested i<j loops, with latency, throughput and reset-abort checks.
module tb_lj_pair_dispatcher;

   localparam int DW = 32;
   localparam int IW = 10;
   localparam int PW = 4 * DW;
   localparam int W  = 2 * IW + 1;

   logic          clk = 1'b0;
   logic          rst, start, pair_ready;
   logic [IW:0]   particle_count;
   logic          busy, done, rd_en, pair_valid, last_pair;
   logic [IW-1:0] rd_addr, ref_id, neighbor_id;
   logic [PW-1:0] rd_data, ref_pos, neighbor;
   logic [2:0]    fsm_state;

   always #5 clk = ~clk;

   lj_pair_dispatcher #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .particle_count(particle_count),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .pair_valid(pair_valid), .pair_ready(pair_ready), .ref_pos(ref_pos),
      .neighbor(neighbor), .ref_id(ref_id), .neighbor_id(neighbor_id),
      .last_pair(last_pair), .fsm_state(fsm_state)
   );

   logic [PW-1:0] pos_mem [0:(1<<IW)-1];
   always @(posedge clk) if (rd_en) rd_data <= pos_mem[rd_addr];

   // Scoreboard: expected pairs {i, j, last}, expected read addresses and read kinds.
   logic [W-1:0]  exp_q [$];
   logic [IW-1:0] rd_q [$];
   bit            kind_q [$];
   int total = 0, bad = 0, cyc = 0;
   int hs_count, nb_issued, done_count, first_hs, last_hs, first_valid, done_cyc;
   bit            prev_stall;
   logic [PW-1:0] prev_ref, prev_nb;
   logic [W-1:0]  prev_tag;

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic build_model(input int n);
      exp_q.delete(); rd_q.delete(); kind_q.delete();
      for (int k = 0; k < n; k++) pos_mem[k] = {$urandom, $urandom, $urandom, DW'(k)};
      for (int i = 0; i < n - 1; i++) begin
         rd_q.push_back(IW'(i)); kind_q.push_back(1'b0);
         for (int j = i + 1; j < n; j++) begin
            rd_q.push_back(IW'(j)); kind_q.push_back(1'b1);
            exp_q.push_back({IW'(i), IW'(j), (i == n - 2) && (j == n - 1)});
         end
      end
   endtask

   task automatic observe();
      logic          hs;
      logic [W-1:0]  e;
      logic [IW-1:0] a;
      hs = pair_valid && pair_ready;
      if (prev_stall) begin
         check("hold_valid", PW'(pair_valid), PW'(1'b1));
         check("hold_ref", ref_pos, prev_ref);
         check("hold_neighbor", neighbor, prev_nb);
         check("hold_tag", PW'({ref_id, neighbor_id, last_pair}), PW'(prev_tag));
      end
      prev_stall = pair_valid && !pair_ready;
      prev_ref   = ref_pos;
      prev_nb    = neighbor;
      prev_tag   = {ref_id, neighbor_id, last_pair};
      if (rd_en) begin
         check("read_in_plan", PW'(rd_q.size() > 0), PW'(1'b1));
         if (rd_q.size() > 0) begin
            a = rd_q.pop_front();
            check("rd_addr", PW'(rd_addr), PW'(a));
            if (kind_q.pop_front()) begin
               check("credit", PW'((nb_issued - hs_count - int'(hs)) < 2), PW'(1'b1));
               nb_issued++;
            end
         end
      end
      if (hs) begin
         check("pair_in_plan", PW'(exp_q.size() > 0), PW'(1'b1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ref_id", PW'(ref_id), PW'(e[W-1:IW+1]));
            check("neighbor_id", PW'(neighbor_id), PW'(e[IW:1]));
            check("ref_pos", ref_pos, pos_mem[e[W-1:IW+1]]);
            check("neighbor_pos", neighbor, pos_mem[e[IW:1]]);
            check("last_pair", PW'(last_pair), PW'(e[0]));
         end
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         hs_count++;
      end
      if (pair_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
   endtask

   task automatic run_cycle(input bit rdy, input bit st);
      pair_ready = rdy;
      start      = st;
      @(negedge clk);
      cyc++;
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic run_pass(input int n, input int pct, input bit disturb, input int rst_after);
      int k0, npairs;
      bit fin, st;
      npairs = (n * (n - 1)) / 2;
      build_model(n);
      hs_count = 0; nb_issued = 0; done_count = 0;
      first_hs = -1; last_hs = -1; first_valid = -1; done_cyc = -1; prev_stall = 0;
      particle_count = (IW + 1)'(n);
      k0  = cyc + 1;
      fin = 0;
      run_cycle($urandom_range(99) < pct, 1'b1);
      for (int c = 0; c < 3000 && !fin; c++) begin
         st = 0;
         if (disturb) begin
            particle_count = (IW + 1)'($urandom_range(20));
            st = ($urandom_range(3) == 0);
         end
         run_cycle($urandom_range(99) < pct, st);
         fin = (done_count > 0) || (rst_after > 0 && hs_count >= rst_after);
      end
      if (rst_after > 0) begin
         check("hs_before_reset", PW'(hs_count), PW'(rst_after));
         rst = 1'b1;
         run_cycle(1'b0, 1'b0);
         rst = 1'b0;
         exp_q.delete(); rd_q.delete(); kind_q.delete();
         prev_stall = 0;
         @(negedge clk);
         cyc++;
         check("reset_valid", PW'(pair_valid), PW'(1'b0));
         check("reset_busy", PW'(busy), PW'(1'b0));
         check("reset_rd_en", PW'(rd_en), PW'(1'b0));
         observe();
         @(posedge clk);
         #1;
         repeat (4) run_cycle(1'b1, 1'b0);
         check("no_done_after_reset", PW'(done_count), PW'(0));
      end else begin
         check("done_count", PW'(done_count), PW'(1));
         check("pair_count", PW'(hs_count), PW'(npairs));
         check("pairs_left", PW'(exp_q.size()), PW'(0));
         check("reads_left", PW'(rd_q.size()), PW'(0));
         if (n >= 2) begin
            check("first_valid_latency", PW'(first_valid - k0), PW'(4));
            check("done_after_last", PW'(done_cyc - last_hs), PW'(1));
            if (pct >= 100) check("handshake_span", PW'(last_hs - first_hs + 1), PW'(npairs + n - 2));
         end else begin
            check("no_valid", PW'(first_valid), PW'(-1));
            check("done_latency", PW'(done_cyc - k0), PW'(2));
         end
         repeat (3) run_cycle(1'b1, 1'b0);
         check("busy_after", PW'(busy), PW'(1'b0));
         check("done_once", PW'(done_count), PW'(1));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pair_ready = 1'b0; particle_count = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_busy", PW'(busy), PW'(1'b0));
      check("rst_done", PW'(done), PW'(1'b0));
      check("rst_rd_en", PW'(rd_en), PW'(1'b0));
      check("rst_rd_addr", PW'(rd_addr), PW'(0));
      check("rst_valid", PW'(pair_valid), PW'(1'b0));
      check("rst_last", PW'(last_pair), PW'(1'b0));
      check("rst_ref", ref_pos, PW'(0));
      check("rst_neighbor", neighbor, PW'(0));
      check("rst_ids", PW'({ref_id, neighbor_id}), PW'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      run_pass(4, 100, 1'b0, 0);
      run_pass(1, 100, 1'b0, 0);
      run_pass(0, 100, 1'b0, 0);
      run_pass(5, 50, 1'b0, 0);
      run_pass(8, 100, 1'b0, 0);
      run_pass(6, 100, 1'b0, 5);
      run_pass(6, 100, 1'b0, 0);
      run_pass(7, 60, 1'b1, 0);
      run_pass(2, 100, 1'b0, 0);
      run_pass(3, 30, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
